// File: rtl/fft_frame_capture_if.sv
// rtl/fft_frame_capture_if.sv - capture/replay stream bundle for fft_frame_capture
//
// Purpose: groups the input stream, output stream and frame status of
//          fft_frame_capture so that a single port carries the whole bus.
// Signals:
//   in_valid/in_ready/in_data/in_last      capture-side valid/ready stream
//   out_valid/out_ready/out_data/out_last  replay-side valid/ready stream
//   frame_len                              samples in the current/last frame
//   frame_done                             one-cycle pulse after the last replay
// Modports:
//   slave   the frame buffer itself
//   master  the environment driving samples in and accepting them out
interface fft_frame_capture_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [ADDR_W:0]   frame_len;
    logic              frame_done;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_len, frame_done
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_len, frame_done
    );
endinterface

// File: rtl/fft_frame_capture.sv
// rtl/fft_frame_capture.sv - FFT output frame buffer: capture a stream, then replay it
//
// Purpose: collects one frame of up to DEPTH samples from the input stream into
//          internal memory, then replays it in order on the output stream.
//          Filling and dumping strictly alternate; the block never accepts and
//          emits in the same phase.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any frame in flight
//   bus  fft_frame_capture_if.slave (input stream, output stream, frame status)
// All bus outputs come straight from registers.
module fft_frame_capture #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    fft_frame_capture_if.slave bus
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        DUMP  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    // One bit wider than an address: after the final sample of a full frame
    // is loaded the read pointer reaches DEPTH.
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   frame_len_q, frame_len_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              frame_done_q, frame_done_d;

    logic              mem_we;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        frame_len_d  = frame_len_q;
        in_ready_d   = 1'b0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            FILL: begin
                // in_ready is registered, so it comes up one cycle after reset
                // releases and drops the cycle after the closing accept.
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    // The DEPTH-th accept closes the frame whatever in_last says.
                    if (bus.in_last || (wr_ptr_q == LAST_ADDR)) begin
                        frame_len_d = {1'b0, wr_ptr_q} + LEN_ONE;
                        in_ready_d  = 1'b0;
                        state_d     = PRIME;
                    end
                end
            end

            PRIME: begin
                // Preload sample 0 so the output register is valid on entry to DUMP.
                out_data_d  = mem[0];
                out_valid_d = 1'b1;
                out_last_d  = (frame_len_q == LEN_ONE);
                rd_ptr_d    = LEN_ONE;
                state_d     = DUMP;
            end

            DUMP: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        frame_done_d = 1'b1;
                        wr_ptr_d     = '0;
                        rd_ptr_d     = '0;
                        in_ready_d   = 1'b1;
                        state_d      = FILL;
                    end else begin
                        out_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
                        rd_ptr_d   = rd_ptr_q + LEN_ONE;
                        out_last_d = (rd_ptr_q == (frame_len_q - LEN_ONE));
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_len_q  <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_len_q  <= frame_len_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Sample storage is deliberately left out of reset; only the pointers restart.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_data   = out_data_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_frame_capture.sv
// tb/tb_fft_frame_capture.sv - directed self-checking bench for fft_frame_capture
module tb_fft_frame_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    fft_frame_capture_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    fft_frame_capture #(.DATA_W(32), .DEPTH(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives n samples back-to-back starting on the current negedge; returns on
    // the negedge of the PRIME cycle. junk leaves garbage asserted on the input.
    task automatic fill(input logic [31:0] base, input int n, input bit with_last,
                        input int prev_len, input bit junk);
        for (int i = 0; i < n; i++) begin
            chk("fill_in_ready", bus.in_ready, 1);
            chk("fill_frame_len_held", bus.frame_len, prev_len);
            bus.in_valid = 1'b1;
            bus.in_data  = base + i;
            bus.in_last  = with_last && (i == n - 1);
            @(negedge clk);
        end
        bus.in_valid = junk;
        bus.in_data  = junk ? 32'hDEADBEEF : 32'h0;
        bus.in_last  = junk;
    endtask

    // Collects the replay; returns on the negedge after the final (or abort_at-th) handshake.
    task automatic dump(input logic [31:0] base, input int n, input bit random_ready,
                        input int abort_at);
        int          k       = 0;
        int          guard   = 0;
        bit          stalled = 1'b0;
        bit          rdy;
        logic [31:0] held_data;
        logic        held_last;
        chk("prime_in_ready", bus.in_ready, 0);
        chk("prime_out_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("latency_out_valid", bus.out_valid, 1);
        while (k < n && guard < 400) begin
            if (abort_at != 0 && k == abort_at) break;
            guard++;
            chk("dump_out_valid", bus.out_valid, 1);
            chk("dump_in_ready", bus.in_ready, 0);
            if (stalled) begin
                chk("stall_data_stable", bus.out_data, held_data);
                chk("stall_last_stable", bus.out_last, held_last);
            end
            rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            if (rdy && bus.out_valid === 1'b1) begin
                chk("dump_data", bus.out_data, base + k);
                chk("dump_last", bus.out_last, (k == n - 1) ? 1 : 0);
                k++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_data = bus.out_data;
                held_last = bus.out_last;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        chk("dump_count", k, (abort_at != 0) ? abort_at : n);
    endtask

    task automatic end_frame();
        chk("done_pulse", bus.frame_done, 1);
        chk("done_in_ready", bus.in_ready, 1);
        chk("done_out_valid", bus.out_valid, 0);
        chk("done_out_last", bus.out_last, 0);
    endtask

    task automatic after_done(input int exp_done);
        @(negedge clk);
        chk("done_single_cycle", bus.frame_done, 0);
        chk("done_count", done_cnt, exp_done);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_frame_len", bus.frame_len, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Full frame, in_last on the 32nd sample
        fill(32'h0, 32, 1'b1, 0, 1'b0);
        chk("full_frame_len", bus.frame_len, 32);
        dump(32'h0, 32, 1'b0, 0);
        end_frame();
        after_done(1);
        chk("full_len_held", bus.frame_len, 32);

        // Short frame
        fill(32'hA0, 5, 1'b1, 32, 1'b0);
        chk("short_frame_len", bus.frame_len, 5);
        dump(32'hA0, 5, 1'b0, 0);
        end_frame();
        after_done(2);

        // Backpressure; frame closes on DEPTH with no in_last
        fill(32'h100, 32, 1'b0, 5, 1'b0);
        chk("bp_frame_len", bus.frame_len, 32);
        dump(32'h100, 32, 1'b1, 0);
        end_frame();
        after_done(3);

        // Garbage on the input through PRIME and DUMP
        fill(32'h300, 4, 1'b1, 32, 1'b1);
        chk("junk_frame_len", bus.frame_len, 4);
        dump(32'h300, 4, 1'b0, 0);
        end_frame();
        after_done(4);
        fill(32'h400, 3, 1'b1, 4, 1'b0);
        chk("post_junk_len", bus.frame_len, 3);
        dump(32'h400, 3, 1'b0, 0);
        end_frame();
        after_done(5);

        // Reset after the 10th output handshake
        fill(32'h500, 32, 1'b1, 3, 1'b0);
        dump(32'h500, 32, 1'b0, 10);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_frame_len", bus.frame_len, 0);
        chk("abort_frame_done", bus.frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready_next", bus.in_ready, 1);
        chk("abort_no_done", bus.frame_done, 0);
        chk("abort_done_count", done_cnt, 5);
        fill(32'h1, 3, 1'b1, 0, 1'b0);
        chk("abort_next_len", bus.frame_len, 3);
        dump(32'h1, 3, 1'b0, 0);
        end_frame();
        after_done(6);

        // Back-to-back frames: B starts on A's frame_done cycle
        fill(32'h10, 4, 1'b1, 3, 1'b0);
        dump(32'h10, 4, 1'b0, 0);
        end_frame();
        fill(32'h20, 8, 1'b1, 4, 1'b0);
        chk("b2b_frame_len", bus.frame_len, 8);
        chk("b2b_a_done_count", done_cnt, 7);
        dump(32'h20, 8, 1'b0, 0);
        end_frame();
        after_done(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_capture.md
# fft_frame_capture

Synthesizable frame buffer on the FFT output side. Collects one frame of up to DEPTH samples from a valid/ready stream into internal memory, then replays the frame in order on a second valid/ready stream toward the dump/checker path. It works in the opposite direction to the memory-preload path used for FFT stimulus: stream into memory instead of memory into stream. It alternates strictly between filling and dumping; it never accepts and emits at the same time.

## Interface
- DATA_W, 32: sample width (packed re/im or single word).
- DEPTH, 32: maximum samples per frame; power of two, at least 2.
- ADDR_W, 5: log2(DEPTH).
- clk  input  1  the single clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input sample valid.
- in_ready  output  1  buffer can accept a sample (FILL state only).
- in_data  input  DATA_W  input sample.
- in_last  input  1  final sample of the frame; qualified by in_valid & in_ready.
- out_valid  output  1  out_data holds a valid sample.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DATA_W  replayed sample, registered.
- out_last  output  1  out_data is the final sample of the frame.
- frame_len  output  ADDR_W+1  number of samples captured in the current or last frame.
- frame_done  output  1  one-cycle pulse after the final output handshake.

## Operation
- States: FILL, PRIME, DUMP.
- Reset values:
  - state = FILL; wr_ptr = 0; rd_ptr = 0.
  - in_ready = 0, out_valid = 0, out_last = 0, out_data = 0, frame_len = 0, frame_done = 0.
  - in_ready goes to 1 on the first cycle after rst deasserts.
- FILL:
  - in_ready = 1.
  - On in_valid & in_ready: mem[wr_ptr] <= in_data, wr_ptr increments.
  - The frame closes on an accepted in_last, or on the accept at wr_ptr == DEPTH-1, whichever comes first. in_last is ignored after the DEPTH-th sample because that accept already closes the frame.
  - On close: frame_len <= wr_ptr+1, state <= PRIME, in_ready drops the next cycle.
- PRIME:
  - Single cycle.
  - out_data <= mem[0], out_valid <= 1, out_last <= (frame_len == 1), rd_ptr <= 1, then state <= DUMP.
- DUMP:
  - out_data, out_valid and out_last stay stable while out_valid & !out_ready.
  - On a handshake that is not the last: out_data <= mem[rd_ptr], rd_ptr increments, out_last <= (rd_ptr == frame_len-1).
  - On the handshake with out_last = 1: out_valid <= 0, out_last <= 0, frame_done <= 1 for one cycle, wr_ptr <= 0, rd_ptr <= 0, state <= FILL.
- Any in_valid outside FILL is ignored (in_ready = 0); nothing is written.
- frame_len holds its value through DUMP and into the following FILL until the next frame closes.
- rst in any state, including mid-DUMP, discards the frame: all registers return to their reset values, and no frame_done is produced for the aborted frame.
- Memory contents are not cleared by reset. Only the pointers are.

## Timing
- Input throughput: 1 sample per cycle in FILL.
- Close-to-output latency:
  - The closing accept happens at cycle t.
  - PRIME occurs at t+1.
  - out_valid = 1 with sample 0 at t+2.
- Output throughput: 1 sample per cycle while out_ready = 1.
- Final handshake at cycle u:
  - frame_done = 1 and in_ready = 1 at u+1.
  - The next frame's first accept can happen at u+1.
- Full 32-sample frame with no stalls: 32 fill cycles, 1 PRIME cycle, then 32 dump cycles.
- All outputs are registered. There are no combinational paths from in_* to out_* or from out_ready to in_ready.

## Test plan
- Full frame, DEPTH=32: 32 samples 0x00000000..0x0000001F are sent back-to-back with in_last only on the 32nd and out_ready = 1. Required: frame_len = 32; out_data returns 0x00..0x1F in order on consecutive cycles; out_last is set only with 0x1F; frame_done pulses once.
- Short frame: 5 samples 0xA0..0xA4 with in_last on 0xA4. Required: frame_len = 5; exactly 5 outputs 0xA0..0xA4; out_last with 0xA4; in_ready = 1 again on the cycle after the last handshake.
- Backpressure: full frame, with out_ready toggling in a pseudo-random pattern of 50% duty. Required: out_data, out_valid and out_last stay stable during stalls; no sample is lost or duplicated; the order is preserved.
- Input ignored outside FILL: in_valid is held at 1 with in_data = 0xDEADBEEF throughout PRIME and DUMP. Required: in_ready = 0 throughout; the replayed frame is unchanged; wr_ptr starts at 0 in the next FILL.
- Reset mid-dump: rst is asserted for 1 cycle after the 10th output handshake of a 32-sample frame. Required: out_valid = 0, in_ready = 0 and frame_len = 0 during the reset cycle; in_ready = 1 the next cycle; no frame_done. A following 3-sample frame 0x1..0x3 replays correctly.
- Back-to-back frames: frame A (0x10..0x13) is followed immediately by frame B (0x20..0x27). Required: B's first accept happens on the cycle frame_done pulses for A; frame_len changes from 4 to 8 on the cycle after B's closing accept; B replays 0x20..0x27 in order.
